// File: rtl/ddio_pkg.sv
// Shared word format, CRC parameters and receiver state encoding for the DDIO link.
// The transmitter reuses crc_gen() to append the check bits.
package ddio_pkg;

  localparam int         MESS_LEN  = 12;
  localparam int         CRC_LEN   = 4;
  localparam logic [4:0] POLY      = 5'b10011;
  localparam int         CODE_W    = MESS_LEN + CRC_LEN;
  localparam int         WORD_W    = CODE_W + 2;
  localparam int         START_BIT = WORD_W - 1;
  localparam int         LAST_BIT  = WORD_W - 2;
  localparam int         MSG_LSB   = CRC_LEN;
  localparam int         ERR_W     = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CAPTURE = 3'd1,
    CRC     = 3'd2,
    WRITE   = 3'd3,
    NEXT    = 3'd4,
    LAST    = 3'd5
  } rx_state_e;

  // Remainder of msg * x^CRC_LEN modulo POLY, i.e. the check bits to append.
  function automatic logic [CRC_LEN-1:0] crc_gen(input logic [MESS_LEN-1:0] msg);
    logic [CODE_W-1:0] div;
    div = {msg, {CRC_LEN{1'b0}}};
    for (int i = CODE_W - 1; i >= CRC_LEN; i--) begin
      if (div[i]) begin
        div[i -: (CRC_LEN + 1)] = div[i -: (CRC_LEN + 1)] ^ POLY;
      end
    end
    return div[CRC_LEN-1:0];
  endfunction

endpackage

// File: rtl/crc_div_serial.sv
// Bit-serial polynomial divider: one code-word bit per cycle from the MSB down to
// bit CRC_LEN; the remainder is left in the low CRC_LEN bits of the register.
module crc_div_serial #(
  parameter int               CODE_W  = 16,
  parameter int               CRC_LEN = 4,
  parameter logic [CRC_LEN:0] POLY    = 5'b10011
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CODE_W-1:0]  data_in,
  output logic               done,
  output logic [CRC_LEN-1:0] remainder
);

  localparam int IDX_W = $clog2(CODE_W);

  logic [CODE_W-1:0] div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              run_q, run_d;
  logic [CODE_W-1:0] poly_at_idx;

  // Generator aligned so its top term sits on the bit currently being cleared.
  assign poly_at_idx = CODE_W'(POLY) << (idx_q - IDX_W'(CRC_LEN));
  assign remainder   = div_q[CRC_LEN-1:0];

  always_comb begin
    div_d = div_q;
    idx_d = idx_q;
    run_d = run_q;
    done  = 1'b0;
    if (start) begin
      div_d = data_in;
      idx_d = IDX_W'(CODE_W - 1);
      run_d = 1'b1;
    end else if (run_q) begin
      if (div_q[idx_q]) begin
        div_d = div_q ^ poly_at_idx;
      end
      idx_d = idx_q - IDX_W'(1);
      // done is raised while the final bit is processed, so the caller sees the
      // finished remainder on the very next cycle.
      if (idx_q == IDX_W'(CRC_LEN)) begin
        done  = 1'b1;
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      idx_q <= '0;
      run_q <= 1'b0;
    end else begin
      div_q <= div_d;
      idx_q <= idx_d;
      run_q <= run_d;
    end
  end

endmodule

// File: rtl/ddio_rx_crc_check.sv
// Receive-side CRC checker: captures DDIO words, divides them bit-serially, writes
// each word to RAM with its pass flag in the top bit and tracks error statistics.
module ddio_rx_crc_check #(
  parameter int               MESS_LEN = 12,
  parameter int               CRC_LEN  = 4,
  parameter logic [CRC_LEN:0] POLY     = 5'b10011,
  parameter int               ADDR_W   = 5
) (
  input  logic                         board_clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [MESS_LEN+CRC_LEN+1:0]  rx_data,
  input  logic                         clear_alert,
  output logic [ADDR_W-1:0]            ram_addr,
  output logic [MESS_LEN+CRC_LEN+1:0]  ram_wdata,
  output logic                         ram_wren,
  output logic                         busy,
  output logic                         crc_err_pulse,
  output logic                         frame_done,
  output logic                         LED_alert,
  output logic [5:0]                   err_count,
  output logic                         overrun
);

  import ddio_pkg::*;

  localparam int CODE_BITS = MESS_LEN + CRC_LEN;
  localparam int WORD_BITS = CODE_BITS + 2;
  localparam int START_POS = WORD_BITS - 1;
  localparam int LAST_POS  = WORD_BITS - 2;

  rx_state_e             state_q, state_d;
  logic                  wait_q, wait_d;
  logic [WORD_BITS-1:0]  word_q, word_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [5:0]            err_q, err_d;
  logic                  led_q, led_d;
  logic                  ovr_q, ovr_d;

  logic                  div_start;
  logic                  div_done;
  logic [CRC_LEN-1:0]    div_rem;
  logic                  crc_ok;

  crc_div_serial #(
    .CODE_W  (CODE_BITS),
    .CRC_LEN (CRC_LEN),
    .POLY    (POLY)
  ) u_div (
    .clk       (board_clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .data_in   (word_q[CODE_BITS-1:0]),
    .done      (div_done),
    .remainder (div_rem)
  );

  assign crc_ok    = (div_rem == '0);
  assign busy      = !((state_q == IDLE) || ((state_q == NEXT) && wait_q));
  assign ram_addr  = addr_q;
  assign LED_alert = led_q;
  assign err_count = err_q;
  assign overrun   = ovr_q;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    word_d        = word_q;
    addr_d        = addr_q;
    err_d         = err_q;
    led_d         = led_q;
    ovr_d         = ovr_q;
    div_start     = 1'b0;
    ram_wren      = 1'b0;
    ram_wdata     = '0;
    crc_err_pulse = 1'b0;
    frame_done    = 1'b0;

    if (rx_valid && busy) begin
      ovr_d = 1'b1;
    end
    // A failing WRITE below overrides this clear in the same cycle.
    if (clear_alert) begin
      led_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (rx_valid && rx_data[START_POS]) begin
          word_d  = rx_data;
          addr_d  = '0;
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        div_start = 1'b1;
        state_d   = CRC;
      end
      CRC: begin
        if (div_done) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        ram_wren  = 1'b1;
        ram_wdata = {crc_ok, word_q[LAST_POS:0]};
        if (!crc_ok) begin
          crc_err_pulse = 1'b1;
          led_d         = 1'b1;
          if (err_q != '1) begin
            err_d = err_q + 6'd1;
          end
        end
        wait_d  = 1'b0;
        state_d = word_q[LAST_POS] ? LAST : NEXT;
      end
      NEXT: begin
        if (!wait_q) begin
          addr_d = addr_q + ADDR_W'(1);
          wait_d = 1'b1;
        end else if (rx_valid) begin
          // Any word continues the frame; a start flag restarts it at address 0.
          word_d  = rx_data;
          wait_d  = 1'b0;
          state_d = CAPTURE;
          if (rx_data[START_POS]) begin
            addr_d = '0;
          end
        end
      end
      LAST: begin
        frame_done = 1'b1;
        addr_d     = '0;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge board_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      wait_q  <= 1'b0;
      word_q  <= '0;
      addr_q  <= '0;
      err_q   <= '0;
      led_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
      led_q   <= led_d;
      ovr_q   <= ovr_d;
    end
  end

endmodule
